hvac_actuator_ctrl: RTL

Downstream stage of the AC thermostat unit. It turns the unit's `heating`/`cooling` request levels into protected actuator enables for the heater, compressor and fan. It enforces a minimum run time, a minimum off time (anti-short-cycle), a fan run-on after cooling, and mutual exclusion of heat and cool. All timing is counted in `tick` pulses from a shared prescaler, so the protection intervals are independent of `clk` frequency.

---
 rtl/hvac_pkg.sv | 31 +++
 rtl/hvac_tick_timer.sv | 35 +++
 rtl/hvac_actuator_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC actuator controller: state encoding and
// the state-to-actuator decode used to build the registered enables.
package hvac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAT  = 3'd1,
    ST_COOL  = 3'd2,
    ST_RUNON = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  typedef struct packed {
    logic heat;
    logic cool;
    logic fan;
  } act_t;

  function automatic act_t decode_outputs(input state_t s);
    act_t a;
    a = '0;
    case (s)
      ST_HEAT:  begin a.heat = 1'b1; a.fan = 1'b1; end
      ST_COOL:  begin a.cool = 1'b1; a.fan = 1'b1; end
      ST_RUNON: a.fan = 1'b1;
      default:  a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/hvac_tick_timer.sv
// Tick-driven saturating down-counter shared by every protection interval.
// A load always wins over a same-cycle tick decrement.
module hvac_tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets a value on every path, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (tick && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hvac_actuator_ctrl.sv
// Protected heater/compressor/fan enables: minimum on, minimum off,
// fan run-on after cooling and heat/cool mutual exclusion.
module hvac_actuator_ctrl
  import hvac_pkg::*;
#(
  parameter int MIN_ON    = 3,
  parameter int MIN_OFF   = 2,
  parameter int FAN_RUNON = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       heat_en,
  output logic       cool_en,
  output logic       fan_en,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] MIN_ON_V    = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_V   = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] FAN_RUNON_V = CNT_W'(FAN_RUNON);

  state_t           state_q, state_d;
  act_t             act_q, act_d;
  logic             fault_q, fault_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  hvac_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (heat_req && !cool_req) begin
          state_d  = ST_HEAT;
          load     = 1'b1;
          load_val = MIN_ON_V;
        end else if (cool_req && !heat_req) begin
          state_d  = ST_COOL;
          load     = 1'b1;
          load_val = MIN_ON_V;
        end
      end
      // Both requests high counts as a drop once minimum on-time has elapsed.
      ST_HEAT: begin
        if (zero && (!heat_req || cool_req)) begin
          state_d  = ST_HOLD;
          load     = 1'b1;
          load_val = MIN_OFF_V;
        end
      end
      ST_COOL: begin
        if (zero && (!cool_req || heat_req)) begin
          state_d  = ST_RUNON;
          load     = 1'b1;
          load_val = FAN_RUNON_V;
        end
      end
      ST_RUNON: begin
        if (zero) begin
          state_d  = ST_HOLD;
          load     = 1'b1;
          load_val = MIN_OFF_V;
        end
      end
      ST_HOLD: begin
        if (zero)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Enables are registered from the next state, so they change with state_q.
  assign act_d   = decode_outputs(state_d);
  assign fault_d = heat_req & cool_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      fault_q <= fault_d;
    end
  end

  assign heat_en = act_q.heat;
  assign cool_en = act_q.cool;
  assign fan_en  = act_q.fan;
  assign fault   = fault_q;
  assign state_o = state_q;

endmodule
